// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared constants and helpers for the programmable sequence detector
package seq_det_pkg;

    localparam logic MODE_NOVL = 1'b0;
    localparam logic MODE_OVL  = 1'b1;

    localparam logic [4:0] DEFAULT_PAT = 5'b10101;
    localparam int         DEFAULT_LEN = 5;

    function automatic int len_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/seq_det_window.sv
// rtl/seq_det_window.sv - serial history shift register and saturating fill counter
module seq_det_window #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               shift_en,
    input  logic               bit_in,
    output logic [MAX_LEN-1:0] win,
    output logic [LEN_W-1:0]   fill
);

    // The oldest of MAX_LEN history bits never reaches the window, so it is not stored.
    logic [MAX_LEN-2:0] hist;

    assign win = {hist, bit_in};

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            hist <= '0;
            fill <= '0;
        end else if (shift_en) begin
            hist <= win[MAX_LEN-2:0];
            if (fill != LEN_W'(MAX_LEN)) begin
                fill <= fill + LEN_W'(1);
            end
        end
    end

endmodule

// File: rtl/seq_detector_prog.sv
// rtl/seq_detector_prog.sv - programmable Mealy serial pattern detector with saturating match count
module seq_detector_prog
    import seq_det_pkg::*;
#(
    parameter  int MAX_LEN = 8,
    parameter  int CNT_W   = 8,
    localparam int LEN_W   = len_width(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pat,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_ovl,
    input  logic               in_valid,
    input  logic               data_in,
    output logic               det,
    output logic               det_q,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cfg_err
);

    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;

    logic [MAX_LEN-1:0] win;
    logic [LEN_W-1:0]   fill;
    logic [MAX_LEN-1:0] mask;
    logic               cfg_legal;
    logic               fill_ok;
    logic               pat_ok;
    logic               win_clr;

    seq_det_window #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_window (
        .clk      (clk),
        .rst      (rst),
        .clr      (win_clr),
        .shift_en (in_valid),
        .bit_in   (data_in),
        .win      (win),
        .fill     (fill)
    );

    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (LEN_W'(i) < len_q);
        end
    end

    assign cfg_legal = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    assign fill_ok   = (fill >= (len_q - LEN_W'(1)));
    assign pat_ok    = (((win ^ pat_q) & mask) == '0);

    // A load cycle drops the concurrent bit, so it can never complete a match.
    assign det     = ~rst & in_valid & ~cfg_load & fill_ok & pat_ok;
    assign win_clr = cfg_load | (det & (ovl_q != MODE_OVL));

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q   <= '0;
            len_q   <= LEN_W'(1);
            ovl_q   <= MODE_NOVL;
            cfg_err <= 1'b0;
        end else if (cfg_load) begin
            if (cfg_legal) begin
                pat_q   <= cfg_pat;
                len_q   <= cfg_len;
                ovl_q   <= cfg_ovl;
                cfg_err <= 1'b0;
            end else begin
                cfg_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            match_cnt <= '0;
        end else if (cfg_load && cfg_legal) begin
            match_cnt <= '0;
        end else if (det && (match_cnt != '1)) begin
            match_cnt <= match_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            det_q <= 1'b0;
        end else begin
            det_q <= det;
        end
    end

endmodule
